// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, alu_op codes, fault codes and enums for the multicycle controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_FAULT} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR, C_BAD} iclass_t;
  function automatic iclass_t op_class(input logic [6:0] op);
    return op == OP_R ? C_R : op == OP_I ? C_I : op == OP_LD ? C_LD :
           op == OP_ST ? C_ST : op == OP_BR ? C_BR : C_BAD;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: request/ready handshake and access controls toward the shared memory
interface multicycle_control_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memread;
  logic memwrite;
  modport master(output mem_req, iord, memread, memwrite, input mem_ready);
  modport slave(input mem_req, iord, memread, memwrite, output mem_ready);
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: instruction class + funct fields -> alu_op and illegal-encoding flag
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  iclass_t    cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_op,
  output logic       illegal
);
  logic alu_cls;
  always_comb begin
    alu_cls = cls == C_R || cls == C_I;
    alu_op = cls == C_BR ? ALU_SUB :
             !alu_cls ? ALU_ADD :
             funct3 == 3'b111 ? ALU_AND :
             funct3 == 3'b110 ? ALU_OR :
             (cls == C_R && funct7_5) ? ALU_SUB : ALU_ADD;
    illegal = cls == C_BAD ||
              (cls == C_BR && funct3[2:1] != 2'b00) ||
              (alu_cls && !(funct3 inside {3'b000, 3'b110, 3'b111})) ||
              (cls == C_R && funct7_5 && funct3 != 3'b000);
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake, retire counter and fault detection
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  multicycle_control_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             branch,
  output logic             MemtoReg,
  output logic             ALUsrc,
  output logic             regWrite,
  output logic [2:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             fault,
  output logic [1:0]       fault_code
);
  localparam int SW = $clog2(WAIT_LIMIT + 1);
  state_t state, next;
  iclass_t cls_q, dec_cls;
  logic [2:0] f3_q, dec_f3, dec_alu;
  logic f7_q, dec_f7, illegal, req, timeout;
  logic [SW-1:0] stall_q;
  // DECODE judges the live IR fields; later states reuse the latched copy
  assign dec_cls = state == S_DECODE ? op_class(opcode) : cls_q;
  assign dec_f3 = state == S_DECODE ? funct3 : f3_q;
  assign dec_f7 = state == S_DECODE ? funct7_5 : f7_q;
  assign req = state == S_FETCH || state == S_MEM;
  assign timeout = req && !mem.mem_ready && stall_q == SW'(WAIT_LIMIT - 1);
  alu_op_decode u_dec (
    .cls(dec_cls),
    .funct3(dec_f3),
    .funct7_5(dec_f7),
    .alu_op(dec_alu),
    .illegal(illegal)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cls_q <= C_BAD;
      f3_q <= '0;
      f7_q <= 1'b0;
      stall_q <= '0;
      retired_cnt <= '0;
      fault_code <= FC_NONE;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        cls_q <= dec_cls;
        f3_q <= funct3;
        f7_q <= funct7_5;
      end
      stall_q <= (req && !mem.mem_ready) ? stall_q + 1'b1 : '0;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      if (next == S_FAULT && state != S_FAULT) fault_code <= timeout ? FC_TIMEOUT : FC_ILLEGAL;
    end
  end
  always_comb begin
    next = state;
    mem.mem_req = req;
    mem.iord = 1'b0;
    mem.memread = 1'b0;
    mem.memwrite = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 1'b0;
    branch = 1'b0;
    MemtoReg = 1'b0;
    ALUsrc = 1'b0;
    regWrite = 1'b0;
    alu_op = 3'b000;
    retire = 1'b0;
    fault = 1'b0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        mem.memread = 1'b1;
        ir_write = mem.mem_ready;
        next = mem.mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: next = illegal ? S_FAULT : dec_cls == C_BR ? S_BRANCH : S_EXEC;
      S_EXEC: begin
        ALUsrc = cls_q != C_R;
        alu_op = dec_alu;
        next = (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem.iord = 1'b1;
        ALUsrc = 1'b1;
        alu_op = dec_alu;
        mem.memread = cls_q == C_LD;
        mem.memwrite = cls_q == C_ST;
        pc_write = mem.mem_ready && cls_q == C_ST;
        retire = mem.mem_ready && cls_q == C_ST;
        next = mem.mem_ready ? (cls_q == C_ST ? S_FETCH : S_WB) : timeout ? S_FAULT : S_MEM;
      end
      S_WB: begin
        regWrite = 1'b1;
        MemtoReg = cls_q == C_LD;
        ALUsrc = cls_q != C_R;
        alu_op = dec_alu;
        pc_write = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
        pc_write = 1'b1;
        pc_src = f3_q[0] ? !zero : zero;
        retire = 1'b1;
        next = S_FETCH;
      end
      default: fault = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench, per-cycle expected control vectors queued then compared
module tb_multicycle_control;
  localparam int WL = 4;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0;
  logic zero = 1'b0;
  logic ir_write, pc_write, pc_src, branch, MemtoReg, ALUsrc, regWrite, retire, fault;
  logic [2:0] alu_op, retired_cnt;
  logic [1:0] fault_code;
  multicycle_control_if mem();
  multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .mem(mem), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
    .MemtoReg(MemtoReg), .ALUsrc(ALUsrc), .regWrite(regWrite), .alu_op(alu_op), .retire(retire),
    .retired_cnt(retired_cnt), .fault(fault), .fault_code(fault_code)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic req, iord, rd, wr, irw, pcw, pcs, br, m2r, asrc, rw;
    logic [2:0] op;
    logic ret, flt;
    logic [1:0] fc;
    logic [2:0] cnt;
  } obs_t;
  typedef struct {
    logic rst, rdy, chk;
    obs_t e;
    string tag;
  } stim_t;
  obs_t obs;
  assign obs = {mem.mem_req, mem.iord, mem.memread, mem.memwrite, ir_write, pc_write, pc_src, branch,
                MemtoReg, ALUsrc, regWrite, alu_op, retire, fault, fault_code, retired_cnt};
  stim_t q[$];
  int vectors = 0, miscompares = 0;
  logic [2:0] cnt = '0;
  task automatic push(input string tag, input logic rst, rdy, chk, input obs_t e);
    stim_t s;
    s.tag = tag;
    s.rst = rst;
    s.rdy = rdy;
    s.chk = chk;
    s.e = e;
    q.push_back(s);
  endtask
  task automatic drain();
    stim_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clock);
      reset = s.rst;
      mem.mem_ready = s.rdy;
      #1;
      if (s.chk) begin
        vectors++;
        assert (obs === s.e) else begin
          miscompares++;
          $error("FAIL %s: observed %h expected %h", s.tag, obs, s.e);
        end
      end
    end
  endtask
  task automatic do_reset();
    obs_t e;
    e = '0;
    push("reset", 1'b1, 1'b0, 1'b0, e);
    cnt = '0;
    push("idle", 1'b0, 1'b0, 1'b1, e);
    drain();
  endtask
  task automatic do_fault(input string tag, input logic [1:0] code);
    obs_t e;
    e = '0;
    e.flt = 1'b1;
    e.fc = code;
    e.cnt = cnt;
    for (int k = 0; k < 3; k++) push({tag, "/fault"}, 1'b0, 1'b1, 1'b1, e);
    drain();
  endtask
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7, z,
                           input int fw, mw, input bit abort);
    obs_t e;
    bit r, i, ld, st, b, ill;
    logic [2:0] aop;
    r = op == R; i = op == I; ld = op == LD; st = op == ST; b = op == BR;
    ill = !(r || i || ld || st || b) || ((r || i) && !(f3 inside {3'b000, 3'b110, 3'b111})) ||
          (r && f7 && f3 != 3'b000) || (b && f3 > 3'd1);
    aop = (ld || st) ? 3'b010 : f3 == 3'b111 ? 3'b000 : f3 == 3'b110 ? 3'b001 : (r && f7) ? 3'b110 : 3'b010;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    e = '0; e.req = 1'b1; e.rd = 1'b1; e.cnt = cnt;
    for (int k = 0; k < fw && k < WL; k++) push({tag, "/fetch_wait"}, 1'b0, 1'b0, 1'b1, e);
    if (fw >= WL) begin do_fault(tag, 2'b10); return; end
    e.irw = 1'b1;
    push({tag, "/fetch"}, 1'b0, 1'b1, 1'b1, e);
    e = '0; e.cnt = cnt;
    push({tag, "/decode"}, 1'b0, 1'b0, 1'b1, e);
    if (ill) begin do_fault(tag, 2'b01); return; end
    if (b) begin
      e.br = 1'b1; e.op = 3'b110; e.pcw = 1'b1; e.pcs = f3[0] ? !z : z; e.ret = 1'b1;
      push({tag, "/branch"}, 1'b0, 1'b0, 1'b1, e);
      cnt++;
      drain();
      return;
    end
    e.asrc = !r; e.op = aop;
    push({tag, "/exec"}, 1'b0, 1'b0, 1'b1, e);
    if (ld || st) begin
      e = '0; e.req = 1'b1; e.iord = 1'b1; e.asrc = 1'b1; e.op = 3'b010; e.rd = ld; e.wr = st; e.cnt = cnt;
      if (abort) begin
        push({tag, "/mem_wait"}, 1'b0, 1'b0, 1'b1, e);
        push({tag, "/mem_reset"}, 1'b1, 1'b0, 1'b1, e);
        cnt = '0;
        e = '0;
        push({tag, "/after_reset"}, 1'b0, 1'b0, 1'b1, e);
        drain();
        return;
      end
      for (int k = 0; k < mw && k < WL; k++) push({tag, "/mem_wait"}, 1'b0, 1'b0, 1'b1, e);
      if (mw >= WL) begin do_fault(tag, 2'b10); return; end
      e.pcw = st; e.ret = st;
      push({tag, "/mem"}, 1'b0, 1'b1, 1'b1, e);
      if (st) begin cnt++; drain(); return; end
    end
    e = '0; e.rw = 1'b1; e.m2r = ld; e.asrc = !r; e.op = aop; e.pcw = 1'b1; e.ret = 1'b1; e.cnt = cnt;
    push({tag, "/wb"}, 1'b0, 1'b0, 1'b1, e);
    cnt++;
    drain();
  endtask
  initial begin
    mem.mem_ready = 1'b0;
    do_reset();
    run_instr("add", R, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr("lw", LD, 3'b010, 1'b0, 1'b0, 2, 2, 0);
    run_instr("beq_taken", BR, 3'b000, 1'b0, 1'b1, 0, 0, 0);
    run_instr("beq_not", BR, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr("bne_taken", BR, 3'b001, 1'b0, 1'b0, 0, 0, 0);
    run_instr("sw", ST, 3'b010, 1'b0, 1'b0, 0, 1, 0);
    run_instr("ori", I, 3'b110, 1'b1, 1'b0, 0, 0, 0);
    run_instr("sub_wrap", R, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    run_instr("and", R, 3'b111, 1'b0, 1'b0, 0, 0, 0);
    run_instr("fetch_rdy4", I, 3'b000, 1'b0, 1'b0, WL - 1, 0, 0);
    run_instr("lw_rdy4", LD, 3'b010, 1'b0, 1'b0, 0, WL - 1, 0);
    run_instr("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    do_reset();
    run_instr("r_bad_f3", R, 3'b001, 1'b0, 1'b0, 0, 0, 0);
    do_reset();
    run_instr("or_f7", R, 3'b110, 1'b1, 1'b0, 0, 0, 0);
    do_reset();
    run_instr("bge", BR, 3'b101, 1'b0, 1'b0, 0, 0, 0);
    do_reset();
    run_instr("fetch_timeout", I, 3'b000, 1'b0, 1'b0, WL, 0, 0);
    do_reset();
    run_instr("mem_timeout", ST, 3'b010, 1'b0, 1'b0, 0, WL, 0);
    do_reset();
    run_instr("add_pre", R, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr("sw_reset", ST, 3'b010, 1'b0, 1'b0, 0, 9, 1);
    run_instr("add_after", R, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
